// File: rtl/isa_pkg.sv
// isa_pkg: opcodes, field positions and instruction formats shared by the
// instruction assembler and its field packer.
package isa_pkg;

    localparam int OPC_W  = 5;
    localparam int WORD_W = 32;

    // Opcodes understood by the processor's control decoder
    localparam logic [OPC_W-1:0] OP_R    = 5'b00000;
    localparam logic [OPC_W-1:0] OP_J    = 5'b00001;
    localparam logic [OPC_W-1:0] OP_BNE  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SW   = 5'b00111;
    localparam logic [OPC_W-1:0] OP_LW   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SETX = 5'b10101;
    localparam logic [OPC_W-1:0] OP_BEX  = 5'b10110;
    localparam logic [OPC_W-1:0] OP_ROTR = 5'b11101;

    // Least-significant bit of each field inside the 32-bit word
    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;

    // Immediate widths of the I and JI formats
    localparam int IMM_I_W  = 17;
    localparam int IMM_JI_W = 27;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_JI,
        FMT_JII,
        FMT_ROTR,
        FMT_BAD
    } fmt_e;

    // Map an opcode onto its encoding format; unknown opcodes are FMT_BAD
    function automatic fmt_e opcode_format(input logic [OPC_W-1:0] opcode);
        case (opcode)
            OP_R:                                  return FMT_R;
            OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: return FMT_I;
            OP_J, OP_JAL, OP_BEX, OP_SETX:         return FMT_JI;
            OP_JR:                                 return FMT_JII;
            OP_ROTR:                               return FMT_ROTR;
            default:                               return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/insn_pack.sv
// insn_pack: combinational packer turning decoded fields into one
// instruction word, its format, and an immediate-range verdict.
// Optional feature macro: ASM_IMM_CHECK_EN (immediate range checking).
module insn_pack
    import isa_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        shamt,
    input  logic [4:0]        aluop,
    input  logic [31:0]       imm,
    output logic [WORD_W-1:0] word,
    output fmt_e              fmt,
    output logic              imm_ok
);

    assign fmt = opcode_format(opcode);

    // Place each field at its format-specific position; unused bits stay zero
    always_comb begin
        // NOTE: assign every output first so no path through the case leaves it unassigned and infers a latch.
        word = '0;
        word[OPC_LSB +: OPC_W] = opcode;
        case (fmt)
            FMT_R: begin
                word[RD_LSB +: 5]    = rd;
                word[RS_LSB +: 5]    = rs;
                word[RT_LSB +: 5]    = rt;
                word[SHAMT_LSB +: 5] = shamt;
                word[ALUOP_LSB +: 5] = aluop;
            end
            FMT_I: begin
                word[RD_LSB +: 5]       = rd;
                word[RS_LSB +: 5]       = rs;
                word[IMM_I_W-1:0]       = imm[IMM_I_W-1:0];
            end
            FMT_JI: begin
                // jal, setx and bex use implicit registers, so only the target is packed
                word[IMM_JI_W-1:0]      = imm[IMM_JI_W-1:0];
            end
            FMT_JII: begin
                word[RD_LSB +: 5]       = rd;
            end
            FMT_ROTR: begin
                word[RD_LSB +: 5]       = rd;
                word[RS_LSB +: 5]       = rs;
                word[4:0]               = shamt;
            end
            default: begin
                word = '0;
            end
        endcase
    end

`ifdef ASM_IMM_CHECK_EN
    // Reject immediates that do not fit the field they are packed into
    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I:   imm_ok = (imm[31:16] == {16{imm[16]}});
            FMT_JI:  imm_ok = (imm[31:27] == 5'd0);
            default: imm_ok = 1'b1;
        endcase
    end
`else
    // Immediates are truncated silently; the top five bits are never packed
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:IMM_JI_W];
    assign imm_ok        = 1'b1;
`endif

endmodule

// File: rtl/insn_assembler.sv
// insn_assembler: streaming instruction encoder and program loader. Accepts
// field bundles over valid/ready, encodes them and writes them sequentially
// into instruction memory starting at base_addr.
// Optional feature macro: ASM_IMM_CHECK_EN (immediate range checking in insn_pack).
module insn_assembler
    import isa_pkg::*;
#(
    parameter  int DEPTH  = 4096,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state;
    logic              done_pending;
    logic              we_q;
    logic [ADDR_W-1:0] wr_addr;

    logic [WORD_W-1:0] packed_word;
    fmt_e              fmt;
    logic              imm_ok;

    logic transfer;
    logic word_ok;
    logic write_word;
    logic reject;
    logic at_end;
    logic terminate;

    insn_pack u_pack (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs     (in_rs),
        .rt     (in_rt),
        .shamt  (in_shamt),
        .aluop  (in_aluop),
        .imm    (in_imm),
        .word   (packed_word),
        .fmt    (fmt),
        .imm_ok (imm_ok)
    );

    // start takes priority over a bundle offered in the same cycle
    assign transfer   = in_valid && in_ready && !start;
    assign word_ok    = (fmt != FMT_BAD) && imm_ok;
    assign write_word = transfer && word_ok;
    assign reject     = transfer && !word_ok;
    assign at_end     = (wr_addr == ADDR_W'(DEPTH - 1));
    // The last slot of memory ends the program just like an in_last bundle
    assign terminate  = transfer && (in_last || (word_ok && at_end));

    // A write still in flight when reset arrives must not reach memory
    assign imem_we = we_q && !reset;

    // Load FSM, address/word counters, error capture and output register
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            done_pending <= 1'b0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            we_q         <= 1'b0;
            imem_addr    <= '0;
            imem_data    <= '0;
            wr_addr      <= '0;
            err          <= 1'b0;
            err_addr     <= '0;
            word_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register samples pre-edge values.
            we_q <= 1'b0;
            if (start) begin
                state        <= S_RUN;
                done_pending <= 1'b0;
                in_ready     <= 1'b1;
                busy         <= 1'b1;
                done         <= 1'b0;
                wr_addr      <= base_addr;
                word_count   <= '0;
                err          <= 1'b0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (done_pending) begin
                            // Terminating write has gone out this cycle
                            state        <= S_DONE;
                            done_pending <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            if (write_word) begin
                                we_q       <= 1'b1;
                                imem_addr  <= wr_addr;
                                imem_data  <= packed_word;
                                word_count <= word_count + (ADDR_W + 1)'(1);
                                if (!at_end) begin
                                    wr_addr <= wr_addr + ADDR_W'(1);
                                end
                            end
                            if (reject && !err) begin
                                err      <= 1'b1;
                                err_addr <= wr_addr;
                            end
                            if (terminate) begin
                                done_pending <= 1'b1;
                                in_ready     <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE wait for start
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_insn_assembler.sv
// tb_insn_assembler: scoreboard bench for insn_assembler. The driver pushes
// the expected memory writes produced by a field-level reference model; a
// separate monitor pops and compares whenever the DUT strobes imem_we.
module tb_insn_assembler;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [4:0] OPS [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                                        5'd7, 5'd8, 5'd21, 5'd22, 5'd29, 5'd31};

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [4:0]        in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              busy, done, err;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W:0]   word_count;

    insn_assembler #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_shamt   (in_shamt),
        .in_aluop   (in_aluop),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_addr   (err_addr),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t exp_q[$];

    typedef enum int { PH_IDLE, PH_RUN, PH_PEND, PH_DONE } phase_e;
    phase_e m_phase;
    int     m_addr;
    int     m_count;
    bit     m_err;
    int     m_err_addr;

    // Encode from the ISA description with plain shifts and masks; returns acceptance
    function automatic bit ref_encode(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] alu,
                                      input logic [31:0] imm, output logic [31:0] w);
        logic [31:0] o, d, s, t, h, a;
        bit ok;
        ok = 1'b1;
        o = 32'(op) << 27;
        d = 32'(rd) << 22;
        s = 32'(rs) << 17;
        t = 32'(rt) << 12;
        h = 32'(sh);
        a = 32'(alu) << 2;
        case (op)
            5'd0: w = o | d | s | t | (h << 7) | a;
            5'd2, 5'd5, 5'd6, 5'd7, 5'd8: begin
                w = o | d | s | (imm & 32'h0001_FFFF);
`ifdef ASM_IMM_CHECK_EN
                ok = ($signed(imm) >= -65536) && ($signed(imm) <= 65535);
`endif
            end
            5'd1, 5'd3, 5'd21, 5'd22: begin
                w = o | (imm & 32'h07FF_FFFF);
`ifdef ASM_IMM_CHECK_EN
                ok = (imm < 32'h0800_0000);
`endif
            end
            5'd4:  w = o | d;
            5'd29: w = o | d | s | h;
            default: begin
                w  = 32'd0;
                ok = 1'b0;
            end
        endcase
        return ok;
    endfunction

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(imem_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("write_data", imem_data, mon_e.data);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
        if (m_phase == PH_PEND) m_phase = PH_DONE;
    endtask

    task automatic expect_status();
        @(negedge clock);
        check("in_ready",   32'(in_ready),   32'(m_phase == PH_RUN));
        check("busy",       32'(busy),       32'(m_phase == PH_RUN || m_phase == PH_PEND));
        check("done",       32'(done),       32'(m_phase == PH_DONE));
        check("word_count", 32'(word_count), 32'(m_count));
        check("err",        32'(err),        32'(m_err));
        if (m_err) check("err_addr", 32'(err_addr), 32'(m_err_addr));
    endtask

    task automatic check_reset_outputs();
        @(negedge clock);
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_imem_we",    32'(imem_we),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_imem_addr",  32'(imem_addr),  32'd0);
        check("rst_imem_data",  imem_data,       32'd0);
        check("rst_err_addr",   32'(err_addr),   32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
    endtask

    task automatic model_start(input int b);
        m_phase = PH_RUN;
        m_addr  = b;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (n) begin
            expect_status();
            tick();
        end
    endtask

    task automatic do_start(input int b);
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        in_valid  = 1'b0;
        expect_status();
        tick();
        start = 1'b0;
        model_start(b);
    endtask

    // Offer one bundle for one cycle (optionally colliding with start)
    task automatic send(input bit st, input int b, input logic [4:0] op, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh,
                        input logic [4:0] alu, input logic [31:0] imm, input bit last, input bit push);
        bit          acc, ok, hit_end;
        logic [31:0] w;
        exp_t        e;
        start     = st;
        base_addr = ADDR_W'(b);
        in_valid  = 1'b1;
        in_last   = last;
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_shamt  = sh;
        in_aluop  = alu;
        in_imm    = imm;
        expect_status();
        acc = !st && (m_phase == PH_RUN);
        tick();
        start = 1'b0;
        if (st) begin
            model_start(b);
        end else if (acc) begin
            ok      = ref_encode(op, rd, rs, rt, sh, alu, imm, w);
            hit_end = 1'b0;
            if (ok) begin
                e.addr = ADDR_W'(m_addr);
                e.data = w;
                if (push) exp_q.push_back(e);
                m_count++;
                hit_end = (m_addr == DEPTH - 1);
                if (!hit_end) m_addr++;
            end else if (!m_err) begin
                m_err      = 1'b1;
                m_err_addr = m_addr;
            end
            if (last || hit_end) m_phase = PH_PEND;
        end
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 65535));
            2:       return 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
            default: return 32'($urandom_range(0, 32'h07FF_FFFF));
        endcase
    endfunction

    task automatic send_rand(input bit st, input int b, input bit last);
        logic [4:0] op;
        op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : OPS[$urandom_range(0, 12)];
        send(st, b, op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), rand_imm(), last, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_shamt = '0; in_aluop = '0;
        in_imm = '0;
        m_phase = PH_IDLE; m_addr = 0; m_count = 0; m_err = 1'b0; m_err_addr = 0;

        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        tick();
        idle(2);

        // Directed program: every format plus one bad opcode
        do_start(0);
        send(0, 0, 5'd5,  5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFB, 0, 1);  // addi -5
        send(0, 0, 5'd0,  5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 32'd0,         0, 1);  // add
        send(0, 0, 5'd3,  5'd9, 5'd9, 5'd9, 5'd0, 5'd0, 32'h0000_0100, 0, 1);  // jal
        send(0, 0, 5'd5,  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0001_0000, 0, 1);  // addi out of range
        send(0, 0, 5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 32'd0,         0, 1);  // bad opcode
        send(0, 0, 5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd5,         0, 1);  // setx 5
        send(0, 0, 5'd4,  5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0,         0, 1);  // jr
        send(0, 0, 5'd29, 5'd1, 5'd2, 5'd0, 5'd9, 5'd0, 32'd0,         1, 1);  // rotr, last
        idle(3);

        // End of memory: five back-to-back bundles from DEPTH-4
        do_start(DEPTH - 4);
        for (int i = 0; i < 5; i++)
            send(0, 0, 5'd5, 5'(i), 5'(i + 1), 5'd0, 5'd0, 5'd0, 32'(i * 3), 0, 1);
        idle(3);

        // Restart from DONE at 8; error then clean program ending on in_last
        do_start(8);
        send(0, 0, 5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 1);
        send(0, 0, 5'd8,  5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 32'd12, 0, 1);
        send(0, 0, 5'd7,  5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 32'd16, 0, 1);
        send(0, 0, 5'd1,  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd40, 1, 1);
        idle(2);
        do_start(8);
        idle(1);

        // start colliding with a bundle, then a rejected in_last
        send(0, 0, 5'd2,  5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'h1_0000, 0, 1);
        send(1, 5, 5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd77,     0, 1);
        send(0, 0, 5'd6,  5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 32'd9,      0, 1);
        send(0, 0, 5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0,      1, 1);
        idle(3);

        // Reset the cycle after a transfer: the write is dropped
        do_start(0);
        send(0, 0, 5'd5, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 32'd1, 0, 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        check("reset_drops_write", 32'(imem_we), 32'd0);
        tick();
        m_phase = PH_IDLE; m_addr = 0; m_count = 0; m_err = 1'b0; m_err_addr = 0;
        check_reset_outputs();
        reset = 1'b0;
        tick();
        idle(1);

        // Randomized programs
        for (int r = 0; r < 25; r++) begin
            send_rand(1, int'($urandom_range(0, DEPTH - 1)), 0);
            for (int i = 0; i < 20; i++)
                send_rand($urandom_range(0, 31) == 0, int'($urandom_range(0, DEPTH - 1)),
                          $urandom_range(0, 11) == 0);
            idle(2);
        end

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
